crc_arbiter: RTL and testbench

CRC_ARBITER -- requirements
Module: crc_arbiter

---
 rtl/crc_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_crc_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/crc_arbiter.sv
// Two-requester round-robin front end for a bit-serial CRC engine.
// Grants one 32-bit word, streams it MSB first, then returns the remainder or a timeout error.
module crc_arbiter #(
    parameter int TIMEOUT = 8
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        req0_in,
    input  logic        req1_in,
    input  logic [31:0] data0_in,
    input  logic [31:0] data1_in,
    output logic        ack0_out,
    output logic        ack1_out,
    output logic [15:0] crc_out,
    output logic        valid_out,
    output logic        id_out,
    output logic        err_out,
    output logic        busy_out,
    output logic        eng_start_out,
    output logic        eng_data_out,
    input  logic        eng_done_in,
    input  logic [15:0] eng_r_in
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        SHIFT = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t             state_reg, state_next;
    logic [31:0]        shift_reg, shift_next;
    logic [4:0]         bit_cnt_reg, bit_cnt_next;
    logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic               last_grant_reg, last_grant_next;
    logic               grant_id_reg, grant_id_next;
    logic               grant_sel;

    logic [1:0]         ack_reg, ack_next;
    logic [15:0]        crc_reg, crc_next;
    logic               valid_reg, valid_next;
    logic               id_reg, id_next;
    logic               err_reg, err_next;
    logic               busy_reg, busy_next;
    logic               eng_start_reg, eng_start_next;
    logic               eng_data_reg, eng_data_next;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            wait_cnt_reg   <= '0;
            last_grant_reg <= 1'b1;
            grant_id_reg   <= 1'b0;
            ack_reg        <= '0;
            crc_reg        <= '0;
            valid_reg      <= 1'b0;
            id_reg         <= 1'b0;
            err_reg        <= 1'b0;
            busy_reg       <= 1'b0;
            eng_start_reg  <= 1'b0;
            eng_data_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            bit_cnt_reg    <= bit_cnt_next;
            wait_cnt_reg   <= wait_cnt_next;
            last_grant_reg <= last_grant_next;
            grant_id_reg   <= grant_id_next;
            ack_reg        <= ack_next;
            crc_reg        <= crc_next;
            valid_reg      <= valid_next;
            id_reg         <= id_next;
            err_reg        <= err_next;
            busy_reg       <= busy_next;
            eng_start_reg  <= eng_start_next;
            eng_data_reg   <= eng_data_next;
        end
    end

    // On a tie the requester not served last wins; a lone request always wins.
    always_comb begin
        grant_sel = 1'b0;
        if (req0_in && req1_in) begin
            grant_sel = ~last_grant_reg;
        end else begin
            grant_sel = req1_in;
        end
    end

    // Output registers are loaded with the value belonging to the state being entered,
    // so every output lines up with the state it describes.
    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        bit_cnt_next    = bit_cnt_reg;
        wait_cnt_next   = wait_cnt_reg;
        last_grant_next = last_grant_reg;
        grant_id_next   = grant_id_reg;
        ack_next        = 2'b00;
        crc_next        = crc_reg;
        valid_next      = 1'b0;
        id_next         = id_reg;
        err_next        = err_reg;
        eng_start_next  = 1'b0;
        eng_data_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req0_in || req1_in) begin
                    state_next      = START;
                    shift_next      = grant_sel ? data1_in : data0_in;
                    grant_id_next   = grant_sel;
                    last_grant_next = grant_sel;
                    ack_next        = grant_sel ? 2'b10 : 2'b01;
                    eng_start_next  = 1'b1;
                end
            end
            START: begin
                state_next    = SHIFT;
                eng_data_next = shift_reg[31];
                shift_next    = {shift_reg[30:0], 1'b0};
            end
            SHIFT: begin
                if (bit_cnt_reg == 5'd31) begin
                    state_next    = WAIT;
                    bit_cnt_next  = 5'd0;
                    wait_cnt_next = '0;
                end else begin
                    eng_data_next = shift_reg[31];
                    shift_next    = {shift_reg[30:0], 1'b0};
                    bit_cnt_next  = bit_cnt_reg + 5'd1;
                end
            end
            WAIT: begin
                // Done is only trusted here: the engine keeps it high from the previous job.
                if (eng_done_in) begin
                    state_next    = RESP;
                    crc_next      = eng_r_in;
                    err_next      = 1'b0;
                    valid_next    = 1'b1;
                    id_next       = grant_id_reg;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    state_next    = RESP;
                    crc_next      = 16'h0000;
                    err_next      = 1'b1;
                    valid_next    = 1'b1;
                    id_next       = grant_id_reg;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign ack0_out      = ack_reg[0];
    assign ack1_out      = ack_reg[1];
    assign crc_out       = crc_reg;
    assign valid_out     = valid_reg;
    assign id_out        = id_reg;
    assign err_out       = err_reg;
    assign busy_out      = busy_reg;
    assign eng_start_out = eng_start_reg;
    assign eng_data_out  = eng_data_reg;

endmodule

// File: tb/tb_crc_arbiter.sv
// Directed bench for crc_arbiter: the engine is a stub driven from the bench,
// all outputs are sampled on the falling clock edge.
module tb_crc_arbiter;

    localparam int TIMEOUT = 8;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        req0_in, req1_in;
    logic [31:0] data0_in, data1_in;
    logic        ack0_out, ack1_out;
    logic [15:0] crc_out;
    logic        valid_out, id_out, err_out, busy_out;
    logic        eng_start_out, eng_data_out;
    logic        eng_done_in;
    logic [15:0] eng_r_in;

    int n_checks = 0;
    int n_fail   = 0;

    crc_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .req0_in       (req0_in),
        .req1_in       (req1_in),
        .data0_in      (data0_in),
        .data1_in      (data1_in),
        .ack0_out      (ack0_out),
        .ack1_out      (ack1_out),
        .crc_out       (crc_out),
        .valid_out     (valid_out),
        .id_out        (id_out),
        .err_out       (err_out),
        .busy_out      (busy_out),
        .eng_start_out (eng_start_out),
        .eng_data_out  (eng_data_out),
        .eng_done_in   (eng_done_in),
        .eng_r_in      (eng_r_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {8'h00, ack1_out, ack0_out, crc_out, valid_out, id_out, err_out,
                busy_out, eng_start_out, eng_data_out};
    endfunction

    // Runs one job starting from a falling edge in IDLE with requests already driven.
    // mode 0: done never comes, 1: done raised at WAIT entry, 2: done held high throughout.
    task automatic do_job(input string tag, input logic gid, input logic [31:0] word,
                          input int mode, input logic [15:0] r,
                          input logic [1:0] drop, input bit poke1);
        logic [31:0] ser;
        int starts, stray_acks, early_valids, w;
        logic [15:0] exp_crc;
        exp_crc     = (mode == 0) ? 16'h0000 : r;
        eng_done_in = (mode == 2);
        eng_r_in    = r;
        @(posedge clk_in);
        @(negedge clk_in);
        check({tag, "_ack"}, {30'd0, ack1_out, ack0_out}, gid ? 32'd2 : 32'd1);
        check({tag, "_start_busy"}, {30'd0, eng_start_out, busy_out}, 32'd3);
        starts = 1;
        stray_acks = 0;
        early_valids = 0;
        if (drop[0]) req0_in = 1'b0;
        if (drop[1]) req1_in = 1'b0;
        ser = '0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk_in);
            ser = {ser[30:0], eng_data_out};
            starts += int'(eng_start_out);
            stray_acks += int'(ack0_out | ack1_out);
            early_valids += int'(valid_out);
            if (poke1 && k == 5)  req1_in = 1'b1;
            if (poke1 && k == 20) req1_in = 1'b0;
        end
        check({tag, "_serial"}, ser, word);
        @(negedge clk_in);
        check({tag, "_wait_entry"}, {29'd0, busy_out, valid_out, eng_data_out}, 32'd4);
        if (mode == 1) eng_done_in = 1'b1;
        w = 0;
        for (int i = 0; i < TIMEOUT + 4; i++) begin
            @(negedge clk_in);
            w++;
            starts += int'(eng_start_out);
            stray_acks += int'(ack0_out | ack1_out);
            if (valid_out) break;
        end
        check({tag, "_wait_cycles"}, w, (mode == 0) ? TIMEOUT : 1);
        check({tag, "_crc"}, {16'd0, crc_out}, {16'd0, exp_crc});
        check({tag, "_id_err"}, {30'd0, id_out, err_out}, {30'd0, gid, (mode == 0)});
        check({tag, "_one_start"}, starts, 1);
        check({tag, "_no_stray"}, stray_acks + early_valids, 0);
        $display("job %s: id=%0d crc=%h err=%0d wait=%0d", tag, id_out, crc_out, err_out, w);
        if (mode == 1) eng_done_in = 1'b0;
        @(negedge clk_in);
        check({tag, "_after"}, {14'd0, crc_out, valid_out, busy_out},
              {14'd0, exp_crc, 1'b0, 1'b0});
    endtask

    initial begin
        int bad;
        rst_n_in = 1'b0;
        req0_in = 1'b0; req1_in = 1'b0;
        data0_in = '0;  data1_in = '0;
        eng_done_in = 1'b0; eng_r_in = '0;
        repeat (3) @(negedge clk_in);
        check("reset_outs", all_outs(), 32'd0);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        check("idle_after_reset", all_outs(), 32'd0);

        // Tie held for three jobs: grants 0,1,0 starting from the reset pointer.
        data0_in = 32'h1111_2222; data1_in = 32'h3333_4444;
        req0_in = 1'b1; req1_in = 1'b1;
        do_job("tie0", 1'b0, 32'h1111_2222, 1, 16'h0101, 2'b00, 1'b0);
        do_job("tie1", 1'b1, 32'h3333_4444, 1, 16'h0202, 2'b00, 1'b0);
        do_job("tie2", 1'b0, 32'h1111_2222, 1, 16'h0303, 2'b11, 1'b0);

        // Single job from requester 0.
        data0_in = 32'hA5A5_0F0F; req0_in = 1'b1;
        do_job("single", 1'b0, 32'hA5A5_0F0F, 1, 16'hBEEF, 2'b01, 1'b0);

        // Stale done held high the whole time.
        data1_in = 32'h0F0F_A5A5; req1_in = 1'b1;
        do_job("stale", 1'b1, 32'h0F0F_A5A5, 2, 16'h1234, 2'b10, 1'b0);

        // Engine never answers, then a normal job.
        data0_in = 32'h1234_5678; req0_in = 1'b1;
        do_job("timeout", 1'b0, 32'h1234_5678, 0, 16'hFFFF, 2'b01, 1'b0);
        data1_in = 32'h8765_4321; req1_in = 1'b1;
        do_job("post_to", 1'b1, 32'h8765_4321, 1, 16'hC0DE, 2'b10, 1'b0);

        // Requester 1 raises and withdraws its request while busy.
        data0_in = 32'h0000_FFFF; req0_in = 1'b1;
        do_job("withdraw", 1'b0, 32'h0000_FFFF, 1, 16'h7777, 2'b01, 1'b1);
        bad = 0;
        repeat (4) begin
            @(negedge clk_in);
            bad += int'(ack1_out | valid_out | busy_out);
        end
        check("withdraw_idle", bad, 0);

        // Reset in SHIFT cycle 10 with requester 1 pending.
        data0_in = 32'hDEAD_BEEF; req0_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        check("rst_job_ack", {30'd0, ack1_out, ack0_out}, 32'd1);
        req0_in = 1'b0;
        data1_in = 32'hCAFE_F00D; req1_in = 1'b1;
        repeat (10) @(negedge clk_in);
        @(posedge clk_in);
        #2 rst_n_in = 1'b0;
        #1 check("rst_async_outs", all_outs(), 32'd0);
        bad = 0;
        repeat (3) begin
            @(negedge clk_in);
            bad += int'(valid_out | ack0_out | ack1_out | busy_out);
        end
        check("rst_held_quiet", bad, 0);
        rst_n_in = 1'b1;
        do_job("rst_rel", 1'b1, 32'hCAFE_F00D, 1, 16'h5A5A, 2'b10, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
